// File: rtl/pvt_scan_monitor_if.sv
// Control, status and readout bundle for pvt_scan_monitor.
// The master side is the host/readout mux; the slave side is the monitor.
interface pvt_scan_monitor_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int WIN_W = 12
);
    localparam int SEL_W = $clog2(N_CH);

    logic             start;
    logic             continuous;
    logic             clear_stats;
    logic [WIN_W-1:0] win_len;
    logic [SEL_W-1:0] rd_sel;
    logic [1:0]       rd_mode;
    logic [CNT_W-1:0] rd_data;
    logic             busy;
    logic             done;
    logic [N_CH-1:0]  ch_valid;

    modport master (
        output start, continuous, clear_stats, win_len, rd_sel, rd_mode,
        input  rd_data, busy, done, ch_valid
    );

    modport slave (
        input  start, continuous, clear_stats, win_len, rd_sel, rd_mode,
        output rd_data, busy, done, ch_valid
    );
endinterface

// File: rtl/pvt_scan_monitor.sv
// Ring-oscillator scan sequencer: enables one channel at a time, counts its
// synchronised rising edges over a window of clk cycles and keeps last/min/max
// results per channel behind a single indexed read port.
module pvt_scan_monitor #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int WIN_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   osc_in,
    output logic [N_CH-1:0]   osc_en,
    pvt_scan_monitor_if.slave bus
);
    localparam int SEL_W = $clog2(N_CH);
    localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(3);
    localparam logic [SEL_W-1:0] CH_LAST     = SEL_W'(N_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_COUNT,
        S_STORE,
        S_FINISH
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_ch;
    logic [WIN_W-1:0] r_win;
    logic [WIN_W-1:0] r_tmr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cnt_ovf;
    logic [N_CH-1:0]  r_sync1;
    logic [N_CH-1:0]  r_sync2;
    logic [N_CH-1:0]  r_sync3;
    logic [CNT_W-1:0] r_last [N_CH];
    logic [CNT_W-1:0] r_min  [N_CH];
    logic [CNT_W-1:0] r_max  [N_CH];
    logic [N_CH-1:0]  r_valid;
    logic [N_CH-1:0]  r_ovf;

    logic             w_begin_scan;
    logic             w_to_count;
    logic             w_next_ch;
    logic             w_store;
    logic             w_edge;
    logic             w_sel_ok;
    logic [WIN_W-1:0] w_win_eff;

    // A zero window length is run as a one-cycle window.
    assign w_win_eff = (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
    assign w_edge    = r_sync2[r_ch] & ~r_sync3[r_ch];
    assign w_sel_ok  = ({1'b0, bus.rd_sel} <= (SEL_W + 1)'(N_CH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and sequencing strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_begin_scan = 1'b0;
        w_to_count   = 1'b0;
        w_next_ch    = 1'b0;
        w_store      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_begin_scan = 1'b1;
                    w_state_nxt  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_tmr == '0) begin
                    w_to_count  = 1'b1;
                    w_state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                if (r_tmr == '0) begin
                    w_state_nxt = S_STORE;
                end
            end
            S_STORE: begin
                w_store = 1'b1;
                if (r_ch == CH_LAST) begin
                    w_state_nxt = S_FINISH;
                end else begin
                    w_next_ch   = 1'b1;
                    w_state_nxt = S_SETTLE;
                end
            end
            S_FINISH: begin
                if (bus.continuous) begin
                    w_begin_scan = 1'b1;
                    w_state_nxt  = S_SETTLE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Status outputs and oscillator enable decoded from the current state.
    always_comb begin
        bus.busy     = (r_state == S_SETTLE) || (r_state == S_COUNT) || (r_state == S_STORE);
        bus.done     = (r_state == S_FINISH);
        bus.ch_valid = r_valid;
        osc_en       = '0;
        if ((r_state == S_SETTLE) || (r_state == S_COUNT)) begin
            osc_en = N_CH'(1) << r_ch;
        end
    end

    // Channel index, latched window length and the shared settle/window down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch  <= '0;
            r_win <= WIN_W'(1);
            r_tmr <= '0;
        end else if (w_begin_scan) begin
            r_ch  <= '0;
            r_win <= w_win_eff;
            r_tmr <= SETTLE_LAST;
        end else if (w_next_ch) begin
            r_ch  <= r_ch + 1'b1;
            r_tmr <= SETTLE_LAST;
        end else if (w_to_count) begin
            r_tmr <= r_win - 1'b1;
        end else if (r_tmr != '0) begin
            r_tmr <= r_tmr - 1'b1;
        end
    end

    // Two-flop synchronisers plus one delay stage for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= osc_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Saturating edge counter for the active channel; cleared outside COUNT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_cnt_ovf <= 1'b0;
        end else if (r_state == S_COUNT) begin
            if (w_edge) begin
                if (r_cnt == '1) begin
                    r_cnt_ovf <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end else begin
            r_cnt     <= '0;
            r_cnt_ovf <= 1'b0;
        end
    end

    // Per-channel statistics; a STORE in the same cycle as a clear overrides the clear for that channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_last[i] <= '0;
                r_min[i]  <= '1;
                r_max[i]  <= '0;
            end
            r_valid <= '0;
            r_ovf   <= '0;
        end else begin
            if (bus.clear_stats) begin
                for (int unsigned i = 0; i < N_CH; i++) begin
                    r_min[i] <= '1;
                    r_max[i] <= '0;
                end
                r_valid <= '0;
                r_ovf   <= '0;
            end
            if (w_store) begin
                r_last[r_ch]  <= r_cnt;
                r_min[r_ch]   <= (bus.clear_stats || (r_cnt < r_min[r_ch])) ? r_cnt : r_min[r_ch];
                r_max[r_ch]   <= (bus.clear_stats || (r_cnt > r_max[r_ch])) ? r_cnt : r_max[r_ch];
                r_valid[r_ch] <= 1'b1;
                r_ovf[r_ch]   <= r_cnt_ovf | (r_ovf[r_ch] & ~bus.clear_stats);
            end
        end
    end

    // Combinational readout of the selected channel register.
    always_comb begin
        bus.rd_data = '0;
        if (w_sel_ok) begin
            case (bus.rd_mode)
                2'b00:   bus.rd_data = r_last[bus.rd_sel];
                2'b01:   bus.rd_data = r_min[bus.rd_sel];
                2'b10:   bus.rd_data = r_max[bus.rd_sel];
                default: bus.rd_data = {r_ovf[bus.rd_sel], r_valid[bus.rd_sel], {(CNT_W - 2){1'b0}}};
            endcase
        end
    end
endmodule

// File: tb/tb_pvt_scan_monitor.sv
// Randomised bench for pvt_scan_monitor: oscillator waveforms are generated
// here, every rising edge is logged by cycle, and expected counts come from
// the scan timeline (per-channel window offsets and 3-cycle edge latency).
module tb_pvt_scan_monitor;
    localparam int N_CH    = 4;
    localparam int CNT_W   = 16;
    localparam int WIN_W   = 12;
    localparam int SEL_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int S_N     = 2;
    localparam int S_CNT_W = 4;
    localparam int S_WIN_W = 8;

    logic            clk     = 1'b0;
    logic            rst_n   = 1'b0;
    logic [N_CH-1:0] osc_in  = '0;
    logic [N_CH-1:0] osc_en;
    logic [S_N-1:0]  osc2_in = '0;
    logic [S_N-1:0]  osc2_en;

    pvt_scan_monitor_if #(.N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();
    pvt_scan_monitor_if #(.N_CH(S_N), .CNT_W(S_CNT_W), .WIN_W(S_WIN_W)) bus2 ();

    pvt_scan_monitor #(.N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .osc_in (osc_in),
        .osc_en (osc_en),
        .bus    (bus.slave)
    );

    pvt_scan_monitor #(.N_CH(S_N), .CNT_W(S_CNT_W), .WIN_W(S_WIN_W)) dut_sat (
        .clk    (clk),
        .rst_n  (rst_n),
        .osc_in (osc2_in),
        .osc_en (osc2_en),
        .bus    (bus2.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int per [N_CH];
    int ph  [N_CH];
    int edges [N_CH][$];

    int m_last [N_CH];
    int m_min  [N_CH];
    int m_max  [N_CH];
    bit m_valid[N_CH];
    bit m_ovf  [N_CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Oscillator driver: new values 2 time units after each edge; rising edges logged by cycle.
    initial begin
        logic [N_CH-1:0] v;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            for (int k = 0; k < N_CH; k++) begin
                v[k] = (((cyc + ph[k]) % per[k]) < (per[k] / 2));
                if (v[k] && !osc_in[k]) edges[k].push_back(cyc);
            end
            osc_in  = v;
            osc2_in = {((cyc % 16) < 8), ((cyc % 2) == 1)};
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Edges occurring in cycle n reach the counter at edge n+3; channel k counts from
    // edge s+5+k*(5+w) to s+4+w+k*(5+w).
    function automatic int count_win(input int k, input int s, input int w);
        int lo = s + 2 + k * (5 + w);
        int hi = s + 1 + w + k * (5 + w);
        int c  = 0;
        for (int i = 0; i < edges[k].size(); i++)
            if (edges[k][i] >= lo && edges[k][i] <= hi) c++;
        return c;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < N_CH; k++) begin
            m_min[k] = CNT_MAX; m_max[k] = 0; m_valid[k] = 0; m_ovf[k] = 0;
        end
    endfunction

    function automatic void model_reset();
        model_clear();
        for (int k = 0; k < N_CH; k++) m_last[k] = 0;
    endfunction

    function automatic void model_store(input int k, input int e);
        int v = (e > CNT_MAX) ? CNT_MAX : e;
        m_last[k]  = v;
        if (v < m_min[k]) m_min[k] = v;
        if (v > m_max[k]) m_max[k] = v;
        m_valid[k] = 1;
        if (e > CNT_MAX) m_ovf[k] = 1;
    endfunction

    task automatic check_regs(input string tag);
        logic [N_CH-1:0] vexp;
        int exp;
        for (int k = 0; k < N_CH; k++) vexp[k] = m_valid[k];
        check({tag, "_ch_valid"}, bus.ch_valid, vexp);
        for (int k = 0; k < N_CH; k++) begin
            for (int m = 0; m < 4; m++) begin
                bus.rd_sel  = SEL_W'(k);
                bus.rd_mode = 2'(m);
                #1;
                case (m)
                    0:       exp = m_last[k];
                    1:       exp = m_min[k];
                    2:       exp = m_max[k];
                    default: exp = (int'(m_ovf[k]) << (CNT_W - 1)) | (int'(m_valid[k]) << (CNT_W - 2));
                endcase
                check($sformatf("%s_rd_ch%0d_mode%0d", tag, k, m), bus.rd_data, exp);
            end
        end
    endtask

    task automatic wait_done(input int exp_d);
        int d = -1;
        for (int i = 0; i < 20000 && d < 0; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) d = cyc;
        end
        check("done_cycle", d, exp_d);
        @(negedge clk);
        check("done_pulse_width", bus.done, 0);
    endtask

    task automatic scan(input int wl, input int clr_ch);
        int s, w, e;
        @(posedge clk); #1;
        bus.win_len = WIN_W'(wl);
        bus.start   = 1'b1;
        s = cyc + 1;
        w = (wl == 0) ? 1 : wl;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_rise", bus.busy, 1);
        if (clr_ch >= 0) begin
            e = s + 4 + w + clr_ch * (5 + w);
            repeat (e - s) @(posedge clk);
            #1 bus.clear_stats = 1'b1;
            @(posedge clk); #1;
            bus.clear_stats = 1'b0;
            check("clr_at_store_valid", bus.ch_valid, 32'd1 << clr_ch);
        end
        wait_done(s + N_CH * (5 + w));
        for (int k = 0; k < N_CH; k++) begin
            if (k == clr_ch) model_clear();
            model_store(k, count_win(k, s, w));
        end
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 bus.clear_stats = 1'b1;
        @(posedge clk); #1 bus.clear_stats = 1'b0;
        model_clear();
    endtask

    task automatic scan_cont(input int wl1, input int wl2);
        int s1, s2, w1, w2, nd;
        w1 = (wl1 == 0) ? 1 : wl1;
        w2 = (wl2 == 0) ? 1 : wl2;
        @(posedge clk); #1;
        bus.continuous = 1'b1;
        bus.win_len    = WIN_W'(wl1);
        bus.start      = 1'b1;
        s1 = cyc + 1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.win_len = WIN_W'(wl2);
        repeat (15 + w1) @(posedge clk);
        #1 per[0] = 16;
        wait_done(s1 + N_CH * (5 + w1));
        for (int k = 0; k < N_CH; k++) model_store(k, count_win(k, s1, w1));
        s2 = s1 + N_CH * (5 + w1) + 1;
        @(posedge clk); #1 bus.continuous = 1'b0;
        wait_done(s2 + N_CH * (5 + w2));
        for (int k = 0; k < N_CH; k++) model_store(k, count_win(k, s2, w2));
        nd = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) nd++;
        end
        check("cont_stop_no_done", nd, 0);
        check("cont_stop_busy", bus.busy, 0);
        check("cont_stop_osc_en", osc_en, 0);
    endtask

    task automatic reset_mid_scan();
        int nd;
        @(posedge clk); #1;
        bus.win_len = WIN_W'(64);
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4 + 2 * 69 + 20) @(posedge clk);
        #1 check("count_ch2_osc_en", osc_en, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_osc_en", osc_en, 0);
        check("rst_async_busy", bus.busy, 0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) nd++;
        end
        check("rst_no_done", nd, 0);
        model_reset();
        check_regs("rst_mid");
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        bus.start = 1'b0; bus.continuous = 1'b0; bus.clear_stats = 1'b0;
        bus.win_len = '0; bus.rd_sel = '0; bus.rd_mode = '0;
        bus2.start = 1'b0; bus2.continuous = 1'b0; bus2.clear_stats = 1'b0;
        bus2.win_len = '0; bus2.rd_sel = '0; bus2.rd_mode = '0;
        for (int k = 0; k < N_CH; k++) begin
            per[k] = 8 * (k + 1);
            ph[k]  = 0;
        end
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_osc_en", osc_en, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check_regs("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        scan(64, -1);
        check_regs("plan_w64");

        @(posedge clk); #1;
        bus2.win_len = S_WIN_W'(64);
        bus2.start   = 1'b1;
        @(posedge clk); #1 bus2.start = 1'b0;
        repeat (2 * 69 + 5) @(posedge clk);
        #1;
        check("sat_busy", bus2.busy, 0);
        check("sat_ch_valid", bus2.ch_valid, 2'b11);
        bus2.rd_sel = 1'b0; bus2.rd_mode = 2'b00; #1;
        check("sat_ch0_last", bus2.rd_data, 4'hF);
        bus2.rd_mode = 2'b11; #1;
        check("sat_ch0_flags", bus2.rd_data, 4'hC);
        bus2.rd_sel = 1'b1; #1;
        check("sat_ch1_flags", bus2.rd_data, 4'h4);

        scan(0, -1);
        check_regs("win_zero");

        repeat (4) begin
            for (int k = 0; k < N_CH; k++) begin
                per[k] = 2 * $urandom_range(1, 20);
                ph[k]  = $urandom_range(0, 39);
            end
            scan($urandom_range(8, 150), -1);
            check_regs("rand");
        end

        pulse_clear();
        check_regs("clear_idle");

        for (int k = 0; k < N_CH; k++) begin
            per[k] = 8 * (k + 1);
            ph[k]  = $urandom_range(0, 7);
        end
        scan(64, 1);
        check_regs("clear_at_store");

        per[0] = 8;
        pulse_clear();
        scan_cont(64, 64);
        check_regs("cont");

        reset_mid_scan();
        scan(40, -1);
        check_regs("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pvt_scan_monitor.md
# pvt_scan_monitor

Parametrised successor to the single-shot PVT measurement blocks: a scan sequencer that enables N ring-oscillator channels one at a time, counts each one's edges over a programmable window of `clk` cycles, and keeps the last, minimum and maximum count per channel. It sits between the oscillator macros (`osc_en` drives their enables, `osc_in` takes their outputs) and the top-level readout mux. It replaces per-block muxing with one indexed read port.

## Interface
- `N_CH`, 4: number of oscillator channels (2..16).
- `CNT_W`, 16: result counter width (4..24).
- `WIN_W`, 12: window-length field width.
- `SEL_W`, $clog2(N_CH): derived, channel index width.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  level; sampled in IDLE, begins a scan of channels 0..N_CH-1.
- `continuous`  in  1  when 1 at scan end, next scan starts immediately.
- `clear_stats`  in  1  one-cycle pulse; re-initialises min/max/valid/ovf.
- `win_len`  in  WIN_W  count window in clk cycles; sampled at scan start.
- `osc_in`  in  N_CH  asynchronous oscillator outputs (pre-divided, below clk/2).
- `osc_en`  out  N_CH  one-hot oscillator enable; 0 when idle.
- `rd_sel`  in  SEL_W  channel to read.
- `rd_mode`  in  2  00 last, 01 min, 10 max, 11 {ovf, valid, zero-pad}.
- `rd_data`  out  CNT_W  combinational read of selected register.
- `busy`  out  1  high from scan start to final STORE.
- `done`  out  1  one-cycle pulse after the last channel is stored.
- `ch_valid`  out  N_CH  channel has at least one stored result since clear.

## Operation
- States: IDLE, SETTLE, COUNT, STORE, FINISH.
- IDLE: `start`=1 loads `win_len` (0 treated as 1), ch=0, goes to SETTLE.
- SETTLE: `osc_en[ch]`=1; 4 cycles, no counting (oscillator startup plus 2-flop synchroniser fill).
- COUNT: `osc_en[ch]`=1; window counter runs W cycles; each synchronised rising edge of `osc_in[ch]` (2-flop sync plus edge detect) increments the result counter.
- The result counter saturates at 2^CNT_W-1 and sets sticky `ovf[ch]`.
- STORE, 1 cycle: last[ch]=count; min[ch]=min(min, count); max[ch]=max(max, count); `ch_valid[ch]`=1; counter cleared. `osc_en` drops this cycle. Then ch+1 goes to SETTLE, or after ch=N_CH-1 goes to FINISH.
- FINISH, 1 cycle: `done`=1, `busy`=0. Then SETTLE with ch=0 and `win_len` re-sampled if `continuous`=1, else IDLE.
- `start` while busy is ignored; `win_len` changes mid-scan take effect at the next scan.
- `clear_stats`: min to all-ones, max to 0, valid and ovf to 0; last is kept. If it coincides with STORE, the STORE values win for that channel only.
- Only the synchronised `osc_in` of the active channel is counted. Inactive channels are ignored.

## Timing
- Reset values: `osc_en`=0, `busy`=0, `done`=0, `ch_valid`=0, all last/max=0, all min=all-ones, ovf=0, state IDLE, ch=0.
- `rst_n` low mid-scan aborts immediately to the reset values; no `done` is produced.
- Per channel: 4 + W + 1 cycles. Full scan: N_CH·(5+W) + 1 cycles from the cycle after `start` is sampled to the `done` pulse.
- `busy` rises the cycle after `start` is sampled.
- `rd_data` is valid the same cycle as `rd_sel`/`rd_mode`. A STORE updates it the following cycle.
- Counting latency: an edge reaches the counter 3 cycles after it occurs at `osc_in`. Edges in the final 3 window cycles carry into the settle pipeline and are discarded on the next channel because the synchroniser is per channel.

## Test plan
- Single scan, N_CH=4, `win_len`=64, `osc_in[k]` toggling with period 8·(k+1) clk cycles -> last = 8, 4, 2 or 3, 2 (±1 phase); `done` exactly 277 cycles after start sampled; `ch_valid`=4'hF.
- Saturation, CNT_W=4, period 2 clk, `win_len`=64 -> last=15, rd_mode 11 shows ovf=1; other channels have ovf=0.
- `win_len`=0 -> behaves as W=1; scan length is N_CH·6+1 cycles; counts are 0 or 1.
- Continuous mode, two scans with channel 0 period changed between them (8 then 16, W=64) -> min=4, max=8, last=4. Deasserting `continuous` mid-scan -> returns to IDLE after that scan's `done`.
- Reset asserted during COUNT of ch 2 -> `osc_en`=0 and `busy`=0 asynchronously; no `done`; all registers at reset values; a new `start` completes normally.
- `clear_stats` between scans -> min reads FFFF, max 0, valid 0 while last is unchanged; clear coincident with STORE of ch 1 -> ch 1 min/max equal the new count and `ch_valid`=4'b0010.
